maze_move_ctrl: RTL and testbench
=================================

// Module: maze_move_ctrl
// PURPOSE
//  Player-cursor controller for the maze game: arrow-key input moves the current cell within a
//  parametrised MAX_DIM x MAX_DIM maze bitmap, legal moves only. Press-to-move with hold-delay
//  auto-repeat, goal detection and status pulses. Sits between PS/2 decoder and maze renderer/FSM.
// PARAMETERS
//  MAX_DIM        16          maze side capacity in cells (power of 2, 2..64); bitmap is MAX_DIM^2 bits
//  CW             $clog2(MAX_DIM)  coordinate width (derived localparam, not overridable)
//  HOLD_CYCLES    25_000_000  clocks key must stay held after first move before auto-repeat begins
//  REPEAT_CYCLES  5_000_000   clocks between auto-repeat moves
//  CNT_W          16          move-counter width
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  reset        in   1             synchronous, active-low (0 = reset)
//  enable       in   1             1 = accept keys; 0 = freeze position, FSM to IDLE
//  load         in   1             1-cycle pulse: cursor <= start, clear done/count, FSM to IDLE
//  key_valid    in   1             1 while a key is held
//  key_code     in   8             held key scan code; bits [6:0] compared
//  maze_data    in   MAX_DIM^2     bit (x + MAX_DIM*y) = 1 open cell, 0 wall
//  maze_width   in   CW+1          active width in cells, 1..MAX_DIM
//  maze_height  in   CW+1          active height in cells, 1..MAX_DIM
//  start_x/y    in   CW each       start cell, loaded on reset and load
//  goal_x/y     in   CW each       goal cell
//  curr_x/y     out  CW each       current cell (registered)
//  moved        out  1             1-cycle pulse: cursor changed this cycle
//  bump         out  1             1-cycle pulse: move attempted but blocked (wall or edge)
//  done         out  1             level: cursor reached goal; sticky until load/reset
//  move_count   out  CNT_W         successful moves since load (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at edge): curr <= start, moved=bump=done=0, move_count=0, timer=0, FSM=IDLE.
//  Keys: LEFT 7'h6B, RIGHT 7'h74, UP 7'h75, DOWN 7'h72; any other code = no key.
//  Move attempt (dir): neighbour checked in order: bounds first (x>0, x<maze_width-1, y>0,
//   y<maze_height-1), then bitmap bit of neighbour; bitmap never indexed out of range (no wrap).
//   Legal -> curr updated, moved=1 next cycle; else bump=1 next cycle, curr unchanged.
//  FSM states IDLE, HOLD, REPEAT, DONE; timer counts in HOLD/REPEAT only.
//   IDLE:   arrow held & enable -> attempt move, latch dir, timer=0, -> HOLD.
//   HOLD:   key released or code != latched dir -> IDLE (new key acted on next cycle);
//           timer==HOLD_CYCLES-1 -> attempt move, timer=0, -> REPEAT; else timer++.
//   REPEAT: release/change -> IDLE; timer==REPEAT_CYCLES-1 -> attempt move, timer=0; else timer++.
//   DONE:   all keys ignored; left only by load or reset.
//  Latency: key seen at edge N -> curr/moved/bump valid after edge N+1; first move never waits.
//  Goal: when a legal move lands on (goal_x,goal_y) -> done=1 same edge as curr update, FSM=DONE.
//   Start==goal does not set done (done needs a move).
//  enable=0: FSM -> IDLE, timer=0, no attempts; curr, done, move_count hold.
//  Priority per edge: reset > load > enable=0 > FSM. load during HOLD/REPEAT aborts the repeat.
//  Held key across load: re-treated as a new press (IDLE) unless enable=0.
//  maze_width/height changes take effect at next attempt; caller loads to restore legality.
//  move_count increments on every legal move, saturates at all-ones.
// CONFIGURATION
//  MAZE_MOVE_COUNT_EN defined: move counter implemented as above.
//  Not defined: no counter registers; move_count tied to 0; all other behaviour identical.
// TESTING  (MAX_DIM=16, HOLD_CYCLES=4, REPEAT_CYCLES=2, 4x4 all-open unless noted)
//  1 reset=0 w/ start=(1,2) -> curr=(1,2), done=0, moved=bump=0, move_count=0.
//  2 start (0,0), RIGHT held 1 cycle then released -> curr=(1,0) one edge later, moved 1 cycle, no repeat.
//  3 start (0,0), RIGHT held 20 cycles -> moves at t=1, then t+4, then every 2; stops at x=3, bump each
//    further attempt, curr stays (3,0).
//  4 LEFT at x=0 and UP into a wall cell (bit=0) -> bump=1, curr unchanged, bitmap index never <0.
//  5 goal=(2,0), start (0,0), RIGHT held -> done=1 on arrival at (2,0), further keys ignored; load ->
//    curr=start, done=0, move_count=0.
//  6 enable=0 mid-REPEAT -> no move; enable=1 with key held -> immediate move, HOLD restarts;
//    with MAZE_MOVE_COUNT_EN, move_count equals moved-pulse count; without it, move_count=0.

Source files
------------

// File: rtl/maze_move_ctrl.sv
// -----------------------------------------------------------------------------
// maze_move_ctrl
//
// Player-cursor controller for the maze game. Arrow keys from the PS/2 decoder
// move the current cell through a MAX_DIM x MAX_DIM maze bitmap, accepting only
// legal moves. A key press moves at once. After HOLD_CYCLES of continuous hold
// the move repeats every REPEAT_CYCLES. Reaching the goal cell sets a sticky
// done flag, and further keys are ignored until load or reset.
//
// Optional feature: define MAZE_MOVE_COUNT_EN to build the saturating move
// counter. When it is undefined, move_count is tied to zero and no counter
// registers exist.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   enable       1 = accept keys; 0 = freeze cursor, FSM back to IDLE
//   load         1-cycle pulse: cursor <= start, clear done/count, FSM to IDLE
//   key_valid    1 while a key is held
//   key_code     held key scan code, bits [6:0] decoded
//   maze_data    bit (x + MAX_DIM*y): 1 = open cell, 0 = wall
//   maze_width   active width in cells, 1..MAX_DIM
//   maze_height  active height in cells, 1..MAX_DIM
//   start_x/y    start cell, loaded on reset and load
//   goal_x/y     goal cell
//   curr_x/y     current cell (registered)
//   moved        1-cycle pulse, cursor changed
//   bump         1-cycle pulse, attempted move blocked by wall or edge
//   done         sticky, cursor reached goal
//   move_count   successful moves since load (saturating)
//
// FSM states
//   state     | meaning
//   ST_IDLE   | waiting for an arrow key; a press attempts a move immediately
//   ST_HOLD   | key held after first move, counting down to auto-repeat
//   ST_REPEAT | auto-repeat, one attempt every REPEAT_CYCLES
//   ST_DONE   | goal reached, keys ignored until load/reset
// -----------------------------------------------------------------------------
module maze_move_ctrl #(
    parameter int unsigned MAX_DIM       = 16,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         load,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    input  logic [MAX_DIM*MAX_DIM-1:0]   maze_data,
    input  logic [$clog2(MAX_DIM):0]     maze_width,
    input  logic [$clog2(MAX_DIM):0]     maze_height,
    input  logic [$clog2(MAX_DIM)-1:0]   start_x,
    input  logic [$clog2(MAX_DIM)-1:0]   start_y,
    input  logic [$clog2(MAX_DIM)-1:0]   goal_x,
    input  logic [$clog2(MAX_DIM)-1:0]   goal_y,
    output logic [$clog2(MAX_DIM)-1:0]   curr_x,
    output logic [$clog2(MAX_DIM)-1:0]   curr_y,
    output logic                         moved,
    output logic                         bump,
    output logic                         done,
    output logic [CNT_W-1:0]             move_count
);

    localparam int unsigned CW   = $clog2(MAX_DIM);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    // The timer is a down-counter: it is reloaded with (period - 1) and the
    // attempt fires at terminal count zero. This gives the same cadence as
    // an up-count from 0 to period-1.
    localparam logic [TW-1:0] HOLD_RELOAD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_RELOAD = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_L,
        DIR_R,
        DIR_U,
        DIR_D
    } dir_t;

    state_t          state, state_next;
    dir_t            dir, dir_next;
    logic [TW-1:0]   timer, timer_next;

    dir_t            key_dir;
    logic            key_arrow;
    logic            key_same;

    dir_t            attempt_dir;
    logic            attempt;
    logic [CW-1:0]   nx, ny;
    logic            in_bounds;
    logic            legal;
    logic            hit_goal;

    logic            unused_key_bit;
    assign unused_key_bit = key_code[7];

    // ---------------------------------------------------------------- key decode
    always_comb begin
        key_arrow = key_valid;
        key_dir   = DIR_L;
        case (key_code[6:0])
            7'h6B:   key_dir = DIR_L;
            7'h74:   key_dir = DIR_R;
            7'h75:   key_dir = DIR_U;
            7'h72:   key_dir = DIR_D;
            default: key_arrow = 1'b0;
        endcase
    end

    assign key_same = key_arrow && (key_dir == dir);

    // In IDLE the attempt uses the live key. Otherwise it uses the latched
    // direction. This selection does not depend on the FSM's next-state
    // logic, so there is no combinational loop through the legality check.
    assign attempt_dir = (state == ST_IDLE) ? key_dir : dir;

    // ------------------------------------------------------------ move legality
    // Bounds are checked before the bitmap. The neighbour index is {ny, nx},
    // which spans exactly MAX_DIM^2 bits, so the bitmap read is always in range.
    // An out-of-bounds neighbour is never used because in_bounds gates it.
    always_comb begin
        nx        = curr_x;
        ny        = curr_y;
        in_bounds = 1'b0;
        case (attempt_dir)
            DIR_L: begin
                in_bounds = (curr_x != '0);
                if (in_bounds) nx = curr_x - CW'(1);
            end
            DIR_R: begin
                in_bounds = (({1'b0, curr_x} + (CW+1)'(1)) < maze_width);
                if (in_bounds) nx = curr_x + CW'(1);
            end
            DIR_U: begin
                in_bounds = (curr_y != '0);
                if (in_bounds) ny = curr_y - CW'(1);
            end
            DIR_D: begin
                in_bounds = (({1'b0, curr_y} + (CW+1)'(1)) < maze_height);
                if (in_bounds) ny = curr_y + CW'(1);
            end
            default: in_bounds = 1'b0;
        endcase
    end

    assign legal    = in_bounds && maze_data[{ny, nx}];
    assign hit_goal = (nx == goal_x) && (ny == goal_y);

    // -------------------------------------------------------------- FSM: next
    always_comb begin
        state_next = state;
        timer_next = timer;
        dir_next   = dir;
        attempt    = 1'b0;

        if (load) begin
            state_next = ST_IDLE;
            timer_next = '0;
        end else if (!enable) begin
            // Goal status is sticky. Disabling does not release ST_DONE.
            if (state != ST_DONE) state_next = ST_IDLE;
            timer_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_arrow) begin
                        attempt    = 1'b1;
                        dir_next   = key_dir;
                        timer_next = HOLD_RELOAD;
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!key_same) begin
                        state_next = ST_IDLE;
                        timer_next = '0;
                    end else if (timer == '0) begin
                        attempt    = 1'b1;
                        timer_next = REPEAT_RELOAD;
                        state_next = ST_REPEAT;
                    end else begin
                        timer_next = timer - TW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!key_same) begin
                        state_next = ST_IDLE;
                        timer_next = '0;
                    end else if (timer == '0) begin
                        attempt    = 1'b1;
                        timer_next = REPEAT_RELOAD;
                    end else begin
                        timer_next = timer - TW'(1);
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
            endcase

            if (attempt && legal && hit_goal) begin
                state_next = ST_DONE;
                timer_next = '0;
            end
        end
    end

    // --------------------------------------------------------- FSM: registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            dir    <= DIR_L;
            timer  <= '0;
            curr_x <= start_x;
            curr_y <= start_y;
            moved  <= 1'b0;
            bump   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            dir   <= dir_next;
            timer <= timer_next;
            moved <= attempt && legal;
            bump  <= attempt && !legal;
            if (load) begin
                curr_x <= start_x;
                curr_y <= start_y;
                done   <= 1'b0;
            end else if (attempt && legal) begin
                curr_x <= nx;
                curr_y <= ny;
                if (hit_goal) done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ move counter
`ifdef MAZE_MOVE_COUNT_EN
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (attempt && legal && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign move_count = count;
`else
    assign move_count = '0;
`endif

endmodule

// File: tb/tb_maze_move_ctrl.sv
module tb_maze_move_ctrl;

    localparam int MAX_DIM = 16;
    localparam int CW      = 4;

    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;

    logic                       clk;
    logic                       reset;
    logic                       enable;
    logic                       load;
    logic                       key_valid;
    logic [7:0]                 key_code;
    logic [MAX_DIM*MAX_DIM-1:0] maze_data;
    logic [CW:0]                maze_width;
    logic [CW:0]                maze_height;
    logic [CW-1:0]              start_x, start_y, goal_x, goal_y;
    logic [CW-1:0]              curr_x, curr_y;
    logic                       moved, bump, done;
    logic [15:0]                move_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_moves;

    maze_move_ctrl #(
        .MAX_DIM      (16),
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .maze_data  (maze_data),
        .maze_width (maze_width),
        .maze_height(maze_height),
        .start_x    (start_x),
        .start_y    (start_y),
        .goal_x     (goal_x),
        .goal_y     (goal_y),
        .curr_x     (curr_x),
        .curr_y     (curr_y),
        .moved      (moved),
        .bump       (bump),
        .done       (done),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_count(input int n);
`ifdef MAZE_MOVE_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic do_load(input logic [CW-1:0] sx, input logic [CW-1:0] sy);
        start_x = sx;
        start_y = sy;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        exp_moves = 0;
    endtask

    task automatic press(input logic [7:0] code);
        key_code  = code;
        key_valid = 1'b1;
    endtask

    task automatic release_key();
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    initial begin
        // 4x4 all-open region in a 16x16 bitmap
        maze_data = '0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                maze_data[x + MAX_DIM*y] = 1'b1;
        maze_width  = 5'd4;
        maze_height = 5'd4;
        enable      = 1'b1;
        load        = 1'b0;
        key_valid   = 1'b0;
        key_code    = 8'h00;
        start_x     = 4'd1;
        start_y     = 4'd2;
        goal_x      = 4'd3;
        goal_y      = 4'd3;
        exp_moves   = 0;

        // ---- 1: reset loads start
        reset = 1'b0;
        tick();
        tick();
        check("rst_curr_x", curr_x, 1);
        check("rst_curr_y", curr_y, 2);
        check("rst_done",   done, 0);
        check("rst_moved",  moved, 0);
        check("rst_bump",   bump, 0);
        check("rst_count",  move_count, 0);
        reset = 1'b1;
        tick();
        check("idle_hold_x", curr_x, 1);

        // ---- 2: single short press
        do_load(4'd0, 4'd0);
        check("load_x", curr_x, 0);
        press(K_RIGHT);
        tick();
        check("tap_x", curr_x, 1);
        check("tap_moved", moved, 1);
        release_key();
        tick();
        check("tap_moved_off", moved, 0);
        for (int i = 0; i < 6; i++) tick();
        check("tap_no_repeat_x", curr_x, 1);
        check("tap_count", move_count, exp_count(1));

        // ---- 3: held RIGHT: moves at 1, 5, 7 then bumps every 2 at the edge
        do_load(4'd0, 4'd0);
        press(K_RIGHT);
        for (int t = 1; t <= 20; t++) begin
            tick();
            check($sformatf("hold_moved_t%0d", t), moved, (t == 1 || t == 5 || t == 7) ? 1 : 0);
            check($sformatf("hold_bump_t%0d", t), bump, (t >= 9 && (t % 2) == 1) ? 1 : 0);
            check($sformatf("hold_x_t%0d", t), curr_x, (t < 5) ? 1 : ((t < 7) ? 2 : 3));
        end
        check("hold_y", curr_y, 0);
        check("hold_count", move_count, exp_count(3));
        release_key();
        tick();

        // ---- 4: walls and edges
        maze_data[0] = 1'b0;            // wall at (0,0)
        do_load(4'd0, 4'd1);
        press(K_LEFT);
        tick();
        check("edge_left_bump", bump, 1);
        check("edge_left_moved", moved, 0);
        check("edge_left_x", curr_x, 0);
        release_key();
        tick();
        press(K_UP);
        tick();
        check("wall_up_bump", bump, 1);
        check("wall_up_y", curr_y, 1);
        release_key();
        tick();
        check("bump_pulse_off", bump, 0);
        press(K_DOWN);
        tick();
        check("down_moved", moved, 1);
        check("down_y", curr_y, 2);
        release_key();
        tick();
        maze_data[0] = 1'b1;
        do_load(4'd2, 4'd0);
        press(K_UP);
        tick();
        check("edge_up_bump", bump, 1);
        check("edge_up_y", curr_y, 0);
        release_key();
        tick();
        // narrowed width: x=1 is now the right edge
        maze_width = 5'd2;
        do_load(4'd1, 4'd1);
        press(K_RIGHT);
        tick();
        check("narrow_bump", bump, 1);
        check("narrow_x", curr_x, 1);
        release_key();
        tick();
        maze_width = 5'd4;

        // ---- 5: goal detection
        goal_x = 4'd2;
        goal_y = 4'd0;
        do_load(4'd0, 4'd0);
        press(K_RIGHT);
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("goal_done_t%0d", t), done, (t >= 5) ? 1 : 0);
        end
        check("goal_x", curr_x, 2);
        release_key();
        tick();
        press(K_LEFT);
        tick();
        tick();
        check("done_ignore_x", curr_x, 2);
        check("done_ignore_moved", moved, 0);
        check("done_ignore_bump", bump, 0);
        check("done_count", move_count, exp_count(2));
        release_key();
        do_load(4'd0, 4'd0);
        check("reload_x", curr_x, 0);
        check("reload_done", done, 0);
        check("reload_count", move_count, 0);
        goal_x = 4'd3;
        goal_y = 4'd3;

        // ---- 6: enable drop mid-repeat
        do_load(4'd0, 4'd0);
        press(K_RIGHT);
        for (int t = 1; t <= 5; t++) tick();
        check("en_pre_x", curr_x, 2);
        enable = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check($sformatf("en_off_moved_%0d", t), moved, 0);
            check($sformatf("en_off_x_%0d", t), curr_x, 2);
        end
        enable = 1'b1;
        tick();
        check("en_on_moved", moved, 1);
        check("en_on_x", curr_x, 3);
        for (int t = 1; t <= 4; t++) begin
            tick();
            check($sformatf("en_hold_bump_%0d", t), bump, (t == 4) ? 1 : 0);
            check($sformatf("en_hold_moved_%0d", t), moved, 0);
        end
        check("en_count", move_count, exp_count(3));
        release_key();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
